// File: rtl/lcd_timing_pkg.sv
// -----------------------------------------------------------------------------
// lcd_timing_pkg
// Shared definitions for the LCD timing generator:
//   - 2-bit segment state encoding used by both the horizontal and the
//     vertical machine (ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE)
//   - default panel timing (800x480 visible area)
//   - output widths of the position and frame counters
// -----------------------------------------------------------------------------
package lcd_timing_pkg;

    // Segment states. Both axes share one encoding. The order is the visiting
    // order, so the successor of a state is simply the next code.
    localparam logic [1:0] SEG_ACTIVE = 2'd0;
    localparam logic [1:0] SEG_FRONT  = 2'd1;
    localparam logic [1:0] SEG_SYNC   = 2'd2;
    localparam logic [1:0] SEG_BACK   = 2'd3;

    // Default timing: clocks per pixel, then segment lengths in pixels / lines.
    localparam int DEF_TICK_DIV = 4;
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 40;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;

    // Output widths.
    localparam int X_W  = 11;
    localparam int Y_W  = 10;
    localparam int FC_W = 32;

    // Successor segment; BACK wraps to ACTIVE through the 2-bit overflow.
    function automatic logic [1:0] seg_next(input logic [1:0] seg);
        return seg + 2'd1;
    endfunction

endpackage

// File: rtl/lcd_timing_if.sv
// -----------------------------------------------------------------------------
// lcd_timing_if
// Bundle between the LCD timing generator and its consumers (panel pins and
// the frame-buffer streamer).
//   enable          : run request into the generator
//   lcd_tick        : one-clock pulse on the last clock of every pixel
//   lcd_pclk        : pixel clock to the panel
//   lcd_data_enable : current pixel is visible
//   lcd_hsync_n     : horizontal sync, active low
//   lcd_vsync_n     : vertical sync, active low
//   lcd_next_frame  : one-clock pulse, streamer flush/restart
//   lcd_x, lcd_y    : current column / line over the full line / frame
//   frame_count     : number of lcd_next_frame pulses since reset
// master = the timing generator, slave = the consumer side.
// -----------------------------------------------------------------------------
interface lcd_timing_if;
    import lcd_timing_pkg::*;

    logic            enable;
    logic            lcd_tick;
    logic            lcd_pclk;
    logic            lcd_data_enable;
    logic            lcd_hsync_n;
    logic            lcd_vsync_n;
    logic            lcd_next_frame;
    logic [X_W-1:0]  lcd_x;
    logic [Y_W-1:0]  lcd_y;
    logic [FC_W-1:0] frame_count;

    modport master (
        input  enable,
        output lcd_tick, lcd_pclk, lcd_data_enable, lcd_hsync_n, lcd_vsync_n,
        output lcd_next_frame, lcd_x, lcd_y, frame_count
    );

    modport slave (
        output enable,
        input  lcd_tick, lcd_pclk, lcd_data_enable, lcd_hsync_n, lcd_vsync_n,
        input  lcd_next_frame, lcd_x, lcd_y, frame_count
    );
endinterface

// File: rtl/lcd_timing_axis.sv
// -----------------------------------------------------------------------------
// lcd_timing_axis
// One timing axis: a four-segment state machine (ACTIVE, FRONT, SYNC, BACK)
// with a segment counter and a position counter over the whole period.
// Used once for the horizontal axis (stepped by pixel ticks) and once for the
// vertical axis (stepped by line ends).
//   i_clock        : clock
//   i_reset_n      : synchronous active-low reset
//   i_run          : low clears the axis to ACTIVE / position 0
//   i_advance      : step one unit (pixel or line)
//   o_state_next   : state after this clock (ACTIVE while cleared)
//   o_pos          : position within the period, 0 .. total-1
//   o_wrap         : combinational pulse, the step that leaves BACK
// -----------------------------------------------------------------------------
module lcd_timing_axis
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE = 1,
    parameter int FRONT  = 1,
    parameter int SYNC   = 1,
    parameter int BACK   = 1,
    parameter int POS_W  = 11
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_run,
    input  logic             i_advance,
    output logic [1:0]       o_state_next,
    output logic [POS_W-1:0] o_pos,
    output logic             o_wrap
);

    localparam logic [POS_W-1:0] LAST_ACTIVE = POS_W'(ACTIVE - 1);
    localparam logic [POS_W-1:0] LAST_FRONT  = POS_W'(FRONT - 1);
    localparam logic [POS_W-1:0] LAST_SYNC   = POS_W'(SYNC - 1);
    localparam logic [POS_W-1:0] LAST_BACK   = POS_W'(BACK - 1);

    logic [1:0]       r_state;
    logic [POS_W-1:0] r_seg_cnt;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_seg_last;
    logic             w_seg_end;
    logic [1:0]       w_state_next;

    // Final count of the segment currently being visited.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned and no latch is inferred.
        w_seg_last = LAST_ACTIVE;
        case (r_state)
            SEG_FRONT: w_seg_last = LAST_FRONT;
            SEG_SYNC:  w_seg_last = LAST_SYNC;
            SEG_BACK:  w_seg_last = LAST_BACK;
            default:   w_seg_last = LAST_ACTIVE;
        endcase
    end

    assign w_seg_end = i_advance && (r_seg_cnt == w_seg_last);
    assign o_wrap    = w_seg_end && (r_state == SEG_BACK);

    always_comb begin
        w_state_next = r_state;
        if (!i_reset_n || !i_run) begin
            w_state_next = SEG_ACTIVE;
        end else if (w_seg_end) begin
            w_state_next = seg_next(r_state);
        end
    end

    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!i_reset_n || !i_run) begin
            r_state   <= SEG_ACTIVE;
            r_seg_cnt <= '0;
            r_pos     <= '0;
        end else if (i_advance) begin
            r_state   <= w_state_next;
            r_seg_cnt <= w_seg_end ? '0 : r_seg_cnt + 1'b1;
            r_pos     <= o_wrap ? '0 : r_pos + 1'b1;
        end
    end

    assign o_state_next = w_state_next;
    assign o_pos        = r_pos;

endmodule

// File: rtl/lcd_timing.sv
// -----------------------------------------------------------------------------
// lcd_timing
// Parallel-RGB LCD timing generator: pixel-rate divider, horizontal and
// vertical segment machines, registered panel strobes and a frame-start
// pulse for the frame-buffer streamer.
//   clock    : single clock
//   reset_n  : synchronous active-low reset (also clears frame_count)
//   lcd      : lcd_timing_if.master (enable in; tick, pclk, data enable,
//              syncs, next_frame, x, y, frame_count out)
// With enable low everything idles at ACTIVE/0 with strobes inactive;
// frame_count is held.
// -----------------------------------------------------------------------------
module lcd_timing
    import lcd_timing_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic         clock,
    input  logic         reset_n,
    lcd_timing_if.master lcd
);

    localparam int             DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2);

    logic [DIV_W-1:0] r_div;
    logic             r_data_enable;
    logic             r_hsync_n;
    logic             r_vsync_n;
    logic             r_v_active;
    logic             r_next_frame;
    logic [FC_W-1:0]  r_frame_count;

    logic             w_tick;
    logic             w_line_end;
    logic             w_frame_start;
    logic [1:0]       w_h_state_next;
    logic [1:0]       w_v_state_next;
    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic             w_unused_v_wrap;   // frame end; no output needs it

    // Pixel-rate divider; the tick is the last clock of each pixel period.
    assign w_tick = lcd.enable && (r_div == DIV_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n || !lcd.enable) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    lcd_timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FP),
        .SYNC   (H_SYNC),
        .BACK   (H_BP),
        .POS_W  (X_W)
    ) u_h_axis (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .i_run        (lcd.enable),
        .i_advance    (w_tick),
        .o_state_next (w_h_state_next),
        .o_pos        (w_x),
        .o_wrap       (w_line_end)
    );

    lcd_timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FP),
        .SYNC   (V_SYNC),
        .BACK   (V_BP),
        .POS_W  (Y_W)
    ) u_v_axis (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .i_run        (lcd.enable),
        .i_advance    (w_line_end),
        .o_state_next (w_v_state_next),
        .o_pos        (w_y),
        .o_wrap       (w_unused_v_wrap)
    );

    // r_v_active mirrors "vertical machine is in ACTIVE", so seeing the next
    // state become FRONT marks the line end that closes the visible area.
    assign w_frame_start = r_v_active && (w_v_state_next == SEG_FRONT);

    // Strobes are registered from the next states: they move on the same
    // edge as x/y, i.e. only after a tick, and hold for the whole pixel.
    always_ff @(posedge clock) begin
        if (!reset_n || !lcd.enable) begin
            r_data_enable <= 1'b0;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_v_active    <= 1'b1;
            r_next_frame  <= 1'b0;
        end else begin
            r_data_enable <= (w_h_state_next == SEG_ACTIVE) &&
                             (w_v_state_next == SEG_ACTIVE);
            r_hsync_n     <= (w_h_state_next != SEG_SYNC);
            r_vsync_n     <= (w_v_state_next != SEG_SYNC);
            r_v_active    <= (w_v_state_next == SEG_ACTIVE);
            r_next_frame  <= w_frame_start;
        end
    end

    // Debug frame counter: cleared only by reset, held while disabled.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_frame_count <= '0;
        end else if (lcd.enable && w_frame_start) begin
            r_frame_count <= r_frame_count + 32'd1;
        end
    end

    assign lcd.lcd_tick        = w_tick;
    assign lcd.lcd_pclk        = lcd.enable && (r_div >= DIV_HALF);
    assign lcd.lcd_data_enable = r_data_enable;
    assign lcd.lcd_hsync_n     = r_hsync_n;
    assign lcd.lcd_vsync_n     = r_vsync_n;
    assign lcd.lcd_next_frame  = r_next_frame;
    assign lcd.lcd_x           = w_x;
    assign lcd.lcd_y           = w_y;
    assign lcd.frame_count     = r_frame_count;

endmodule

// File: tb/tb_lcd_timing.sv
// -----------------------------------------------------------------------------
// tb_lcd_timing
// Self-checking bench for lcd_timing with a tiny panel (TICK_DIV=2,
// H 4/1/1/1, V 2/1/1/1). A table of hand-derived vectors covers reset and
// the first line; directed sequences cover frame pulse, sync widths, enable
// drop and mid-frame reset; a random phase runs against a reference model
// that derives everything from the number of enabled clocks since start.
// -----------------------------------------------------------------------------
module tb_lcd_timing;

    localparam int TD = 2;
    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 7
    localparam int VT = VA + VF + VS + VB;   // 5
    localparam int FRAME_CLKS = HT * VT * TD; // 70

    logic clock = 1'b0;
    logic reset_n;

    lcd_timing_if lcd ();

    lcd_timing #(
        .TICK_DIV (TD),
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .lcd     (lcd)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: enabled clocks since the run started, and frames seen.
    int   m_n   = 0;
    logic m_run = 1'b0;
    logic m_nf  = 1'b0;
    int   m_fc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_step(input logic r, input logic e);
        if (!r) begin
            m_n = 0; m_run = 1'b0; m_nf = 1'b0; m_fc = 0;
        end else if (!e) begin
            m_n = 0; m_run = 1'b0; m_nf = 1'b0;
        end else begin
            m_n++;
            m_run = 1'b1;
            // A new pixel index 14 (x=0, y=VA) starts the vertical blanking.
            m_nf = (m_n % TD == 0) && ((m_n / TD) % (HT * VT) == HT * VA);
            if (m_nf) m_fc++;
        end
    endtask

    // Inputs change after the falling edge; outputs are looked at on the
    // following falling edge, after the model saw the rising edge.
    task automatic cycle(input logic r, input logic e);
        reset_n    = r;
        lcd.enable = e;
        @(posedge clock);
        model_step(r, e);
        @(negedge clock);
        cyc++;
    endtask

    task automatic compare_model();
        int px, x, y;
        px = m_n / TD;
        x  = px % HT;
        y  = (px / HT) % VT;
        check("tick", 32'(lcd.lcd_tick), 32'(m_run && (m_n % TD == TD - 1)));
        check("pclk", 32'(lcd.lcd_pclk), 32'(m_run && (m_n % TD >= TD / 2)));
        check("de",   32'(lcd.lcd_data_enable), 32'(m_run && x < HA && y < VA));
        check("hs_n", 32'(lcd.lcd_hsync_n), 32'(!(m_run && x >= HA + HF && x < HA + HF + HS)));
        check("vs_n", 32'(lcd.lcd_vsync_n), 32'(!(m_run && y >= VA + VF && y < VA + VF + VS)));
        check("nf",   32'(lcd.lcd_next_frame), 32'(m_nf));
        check("x",    32'(lcd.lcd_x), 32'(m_run ? x : 0));
        check("y",    32'(lcd.lcd_y), 32'(m_run ? y : 0));
        check("fc",   lcd.frame_count, 32'(m_fc));
    endtask

    task automatic cycle_chk(input logic r, input logic e);
        cycle(r, e);
        compare_model();
    endtask

    typedef struct {
        logic rst_n;
        logic en;
        int   x;
        int   y;
        logic tick;
        logic pclk;
        logic de;
        logic hs_n;
        logic vs_n;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   found, first_cyc, last_tick, min_gap, hs_low, hs_bad, vs_low, vs_bad, ticks;
        int   p_x, p_y, fc_hold, nf_seen;
        logic p_tick, r_v, en_v;

        //            rst en  x  y tick pclk de hs vs
        vecs[0]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 4, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 5, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 6, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 6, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset_n    = 1'b0;
        lcd.enable = 1'b0;
        @(negedge clock);

        // Reset and the first line, from the hand-derived table.
        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].rst_n, vecs[i].en);
            check("t_x",    32'(lcd.lcd_x), 32'(vecs[i].x));
            check("t_y",    32'(lcd.lcd_y), 32'(vecs[i].y));
            check("t_tick", 32'(lcd.lcd_tick), 32'(vecs[i].tick));
            check("t_pclk", 32'(lcd.lcd_pclk), 32'(vecs[i].pclk));
            check("t_de",   32'(lcd.lcd_data_enable), 32'(vecs[i].de));
            check("t_hs_n", 32'(lcd.lcd_hsync_n), 32'(vecs[i].hs_n));
            check("t_vs_n", 32'(lcd.lcd_vsync_n), 32'(vecs[i].vs_n));
            check("t_nf",   32'(lcd.lcd_next_frame), 32'd0);
            check("t_fc",   lcd.frame_count, 32'd0);
        end

        // Frame pulse: one clock after the tick closing line 1 at x=6.
        found = 0; first_cyc = 0; p_tick = 1'b0; p_x = 0; p_y = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            p_tick = lcd.lcd_tick; p_x = int'(lcd.lcd_x); p_y = int'(lcd.lcd_y);
            cycle_chk(1'b1, 1'b1);
            if (lcd.lcd_next_frame) begin found = 1; first_cyc = cyc; end
        end
        check("nf1_seen", 32'(found), 32'd1);
        if (found != 0) begin
            check("nf1_prev_tick", 32'(p_tick), 32'd1);
            check("nf1_prev_x", 32'(p_x), 32'(HT - 1));
            check("nf1_prev_y", 32'(p_y), 32'(VA - 1));
            check("nf1_fc", lcd.frame_count, 32'd1);
        end
        cycle_chk(1'b1, 1'b1);
        check("nf1_width", 32'(lcd.lcd_next_frame), 32'd0);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            cycle_chk(1'b1, 1'b1);
            if (lcd.lcd_next_frame) found = 1;
        end
        check("nf2_seen", 32'(found), 32'd1);
        check("nf2_spacing", 32'(cyc - first_cyc), 32'(FRAME_CLKS));
        check("nf2_fc", lcd.frame_count, 32'd2);

        // One full frame of sync widths and tick spacing.
        hs_low = 0; hs_bad = 0; vs_low = 0; vs_bad = 0; ticks = 0;
        last_tick = -1000; min_gap = 1000;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            cycle_chk(1'b1, 1'b1);
            if (!lcd.lcd_hsync_n) begin
                hs_low++;
                if (lcd.lcd_x != 11'd5) hs_bad++;
            end
            if (!lcd.lcd_vsync_n) begin
                vs_low++;
                if (lcd.lcd_y != 10'd3) vs_bad++;
            end
            if (lcd.lcd_tick) begin
                ticks++;
                if (cyc - last_tick < min_gap) min_gap = cyc - last_tick;
                last_tick = cyc;
            end
        end
        check("hs_low_clocks", 32'(hs_low), 32'(HS * TD * VT));
        check("hs_low_off_x5", 32'(hs_bad), 32'd0);
        check("vs_low_clocks", 32'(vs_low), 32'(VS * HT * TD));
        check("vs_low_off_y3", 32'(vs_bad), 32'd0);
        check("ticks_per_frame", 32'(ticks), 32'(HT * VT));
        check("tick_min_gap", 32'(min_gap), 32'(TD));

        // Enable dropped at x=2, y=1: idle on the next clock, no pulse.
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            cycle_chk(1'b1, 1'b1);
            if (lcd.lcd_x == 11'd2 && lcd.lcd_y == 10'd1) found = 1;
        end
        check("x2y1_reached", 32'(found), 32'd1);
        fc_hold = m_fc;
        cycle_chk(1'b1, 1'b0);
        check("dis_tick", 32'(lcd.lcd_tick), 32'd0);
        check("dis_pclk", 32'(lcd.lcd_pclk), 32'd0);
        check("dis_de",   32'(lcd.lcd_data_enable), 32'd0);
        check("dis_hs_n", 32'(lcd.lcd_hsync_n), 32'd1);
        check("dis_vs_n", 32'(lcd.lcd_vsync_n), 32'd1);
        check("dis_x",    32'(lcd.lcd_x), 32'd0);
        check("dis_y",    32'(lcd.lcd_y), 32'd0);
        check("dis_fc_held", lcd.frame_count, 32'(fc_hold));
        nf_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cycle_chk(1'b1, 1'b0);
            if (lcd.lcd_next_frame) nf_seen++;
        end
        check("dis_no_nf", 32'(nf_seen), 32'd0);
        cycle_chk(1'b1, 1'b1);
        check("reen_x", 32'(lcd.lcd_x), 32'd0);
        check("reen_y", 32'(lcd.lcd_y), 32'd0);
        for (int i = 0; i < 80; i++) cycle_chk(1'b1, 1'b1);

        // Three frames, then a reset in the middle of the fourth.
        for (int i = 0; i < 3 * FRAME_CLKS + 23; i++) cycle_chk(1'b1, 1'b1);
        check("fc_after_3_frames", 32'(lcd.frame_count >= 32'd3), 32'd1);
        cycle_chk(1'b0, 1'b1);
        check("rst_fc",   lcd.frame_count, 32'd0);
        check("rst_hs_n", 32'(lcd.lcd_hsync_n), 32'd1);
        check("rst_vs_n", 32'(lcd.lcd_vsync_n), 32'd1);
        check("rst_tick", 32'(lcd.lcd_tick), 32'd0);
        for (int i = 0; i < 10; i++) cycle_chk(1'b1, 1'b1);

        // Random enable drops and occasional resets against the model.
        en_v = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            r_v = ($urandom_range(0, 399) != 0);
            if (en_v) en_v = ($urandom_range(0, 149) != 0);
            else      en_v = ($urandom_range(0, 4) == 0);
            cycle_chk(r_v, en_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
